// File: rtl/loop_player_if.sv
// Host/consumer-side bundle for loop_player: playback control, sample stream and RAM write port.
// The master drives control and write signals; the slave (the player) drives the stream outputs.
interface loop_player_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIV_W    = 16
) ();
    logic                         r_start;
    logic                         r_stop;
    logic                         r_loop;
    logic [ADDR_W-1:0]            r_first;
    logic [ADDR_W-1:0]            r_last;
    logic [DIV_W-1:0]             r_div;
    logic [CHANNELS*DATA_W-1:0]   r_out;
    logic                         r_valid;
    logic                         r_busy;
    logic                         r_done;
    logic [15:0]                  r_loops;
    logic                         w_enable;
    logic [CHANNELS-1:0]          w_chan;
    logic [ADDR_W-1:0]            w_addr;
    logic [DATA_W-1:0]            w_in;

    modport master (
        output r_start, r_stop, r_loop, r_first, r_last, r_div,
        output w_enable, w_chan, w_addr, w_in,
        input  r_out, r_valid, r_busy, r_done, r_loops
    );

    modport slave (
        input  r_start, r_stop, r_loop, r_first, r_last, r_div,
        input  w_enable, w_chan, w_addr, w_in,
        output r_out, r_valid, r_busy, r_done, r_loops
    );
endinterface

// File: rtl/loop_player.sv
// Multi-channel sample RAM with windowed, rate-divided one-shot/loop playback.
// Writes land on w_clk; the playback cursor and all control live on r_clk.
module loop_player #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIV_W    = 16
) (
    input  logic          r_clk,
    input  logic          r_reset_n,
    input  logic          w_clk,
    loop_player_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StPlay, StFlush} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]          first_q, first_d;
    logic [ADDR_W-1:0]          last_q, last_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       loop_q, loop_d;
    logic [ADDR_W-1:0]          cursor_q, cursor_d;
    logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
    logic [15:0]                loops_q, loops_d;
    logic                       done_q, done_d;
    logic [CHANNELS*DATA_W-1:0] out_q, out_d;
    logic                       valid_q, valid_d;
    logic                       pend_q, pend_d;
    logic                       wrap_q, wrap_d;

    logic                       busy;
    logic                       issue;
    logic                       deliver;
    logic                       at_last;
    logic [CHANNELS*DATA_W-1:0] rd_all;

    // Per-channel RAM: independent write enables, one shared read cursor.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge w_clk) begin
            if (bus.w_enable && bus.w_chan[c]) begin
                mem_q[bus.w_addr] <= bus.w_in;
            end
        end

        always_ff @(posedge r_clk) begin
            if (issue) begin
                rd_q <= mem_q[cursor_q];
            end
        end

        assign rd_all[c*DATA_W +: DATA_W] = rd_q;
    end

    // State register.
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; r_start overrides r_stop.
    always_comb begin
        state_d = state_q;
        if (bus.r_start) begin
            state_d = StPlay;
        end else if (bus.r_stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StPlay:  if (issue && at_last && !loop_q) state_d = StFlush;
                StFlush: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs; a start or stop cancels both the new read and any read in flight.
    always_comb begin
        busy    = (state_q == StPlay) || (state_q == StFlush);
        at_last = (cursor_q == last_q);
        issue   = (state_q == StPlay) && (div_cnt_q == '0) && !bus.r_start && !bus.r_stop;
        deliver = pend_q && !bus.r_start && !bus.r_stop;
    end

    always_comb begin
        first_d   = first_q;
        last_d    = last_q;
        div_d     = div_q;
        loop_d    = loop_q;
        cursor_d  = cursor_q;
        div_cnt_d = div_cnt_q;
        loops_d   = loops_q;
        done_d    = done_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        pend_d    = issue;
        wrap_d    = issue && at_last && loop_q;

        // A pass counts as completed once its final sample reaches r_out.
        if (deliver) begin
            out_d   = rd_all;
            valid_d = 1'b1;
            if (wrap_q && (loops_q != 16'hFFFF)) begin
                loops_d = loops_q + 16'd1;
            end
        end

        if (bus.r_start) begin
            first_d   = bus.r_first;
            last_d    = bus.r_last;
            div_d     = bus.r_div;
            loop_d    = bus.r_loop;
            cursor_d  = bus.r_first;
            div_cnt_d = '0;
            loops_d   = '0;
            done_d    = 1'b0;
        end else if ((state_q == StFlush) && !bus.r_stop) begin
            done_d = 1'b1;
        end else if (issue) begin
            div_cnt_d = div_q;
            if (!at_last) begin
                cursor_d = cursor_q + ADDR_W'(1);
            end else if (loop_q) begin
                cursor_d = first_q;
            end
        end else if ((state_q == StPlay) && !bus.r_stop) begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            first_q   <= '0;
            last_q    <= '0;
            div_q     <= '0;
            loop_q    <= 1'b0;
            cursor_q  <= '0;
            div_cnt_q <= '0;
            loops_q   <= '0;
            done_q    <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            first_q   <= first_d;
            last_q    <= last_d;
            div_q     <= div_d;
            loop_q    <= loop_d;
            cursor_q  <= cursor_d;
            div_cnt_q <= div_cnt_d;
            loops_q   <= loops_d;
            done_q    <= done_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.r_out   = out_q;
    assign bus.r_valid = valid_q;
    assign bus.r_busy  = busy;
    assign bus.r_done  = done_q;
    assign bus.r_loops = loops_q;
endmodule

// File: tb/tb_loop_player.sv
// Randomised and directed playback runs checked cycle by cycle against a window/rate model
// that derives each expected sample and its arrival cycle arithmetically from the config.
module tb_loop_player;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DIV_W    = 16;
    localparam int unsigned DEPTH    = 16;

    logic r_clk = 1'b0;
    logic w_clk = 1'b0;
    logic r_reset_n;

    always #5 r_clk = ~r_clk;
    always #7 w_clk = ~w_clk;

    loop_player_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .DIV_W(DIV_W)
    ) bus ();

    loop_player #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .DIV_W(DIV_W)
    ) dut (
        .r_clk    (r_clk),
        .r_reset_n(r_reset_n),
        .w_clk    (w_clk),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] ref_mem [CHANNELS][DEPTH];
    logic [63:0]       exp_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sample_at(input int addr);
        logic [3:0] a;
        a = addr[3:0];
        return {ref_mem[1][a], ref_mem[0][a]};
    endfunction

    function automatic int win_len(input int first, input int last);
        return ((last - first) & 15) + 1;
    endfunction

    task automatic mem_write(input logic [1:0] chan, input logic [3:0] addr,
                             input logic [31:0] data);
        @(negedge w_clk);
        bus.w_enable = 1'b1;
        bus.w_chan   = chan;
        bus.w_addr   = addr;
        bus.w_in     = data;
        @(posedge w_clk);
        #1 bus.w_enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (chan[c]) ref_mem[c][addr] = data;
        end
    endtask

    task automatic drive_start(input int first, input int last, input int div,
                               input bit loop_m, input bit with_stop);
        @(negedge r_clk);
        bus.r_start = 1'b1;
        bus.r_stop  = with_stop;
        bus.r_first = first[3:0];
        bus.r_last  = last[3:0];
        bus.r_div   = div[15:0];
        bus.r_loop  = loop_m;
        @(negedge r_clk);
        bus.r_start = 1'b0;
        bus.r_stop  = 1'b0;
        // Config inputs must be ignored outside the start cycle.
        bus.r_first = 4'($urandom);
        bus.r_last  = 4'($urandom);
        bus.r_div   = 16'($urandom);
        bus.r_loop  = 1'($urandom);
    endtask

    // Loop-mode play left running unchecked; the model still tracks what r_out ends on,
    // counting deliveries up to the edge just before the next negedge-driven action.
    task automatic blind_play(input int first, input int last, input int div, input int cycles);
        int m;
        int k;
        drive_start(first, last, div, 1'b1, 1'b0);
        repeat (cycles) @(negedge r_clk);
        m = cycles + 1;
        k = (m - 2) / (div + 1);
        exp_out = sample_at(first + (k % win_len(first, last)));
    endtask

    task automatic run_play(input int first, input int last, input int div, input bit loop_m,
                            input int stop_after, input bit with_stop, input string tag);
        int len;
        int n_last;
        int k;
        int delivered;
        bit exp_valid;
        len       = win_len(first, last);
        delivered = 0;
        n_last    = loop_m ? 2 + (stop_after - 1) * (div + 1) : 2 + (len - 1) * (div + 1);
        drive_start(first, last, div, loop_m, with_stop);
        check_eq({tag, " start valid"}, 64'(bus.r_valid), 64'd0);
        check_eq({tag, " start busy"}, 64'(bus.r_busy), 64'd1);
        check_eq({tag, " start done"}, 64'(bus.r_done), 64'd0);
        check_eq({tag, " start loops"}, 64'(bus.r_loops), 64'd0);
        check_eq({tag, " start out"}, bus.r_out, exp_out);
        for (int n = 1; n <= n_last; n++) begin
            @(negedge r_clk);
            exp_valid = (n >= 2) && (((n - 2) % (div + 1)) == 0);
            if (exp_valid) begin
                k = (n - 2) / (div + 1);
                exp_out = sample_at(first + (k % len));
                delivered++;
            end
            check_eq($sformatf("%s valid n=%0d", tag, n), 64'(bus.r_valid), 64'(exp_valid));
            check_eq($sformatf("%s out n=%0d", tag, n), bus.r_out, exp_out);
            check_eq($sformatf("%s busy n=%0d", tag, n), 64'(bus.r_busy),
                     64'(loop_m || (n < n_last)));
            check_eq($sformatf("%s done n=%0d", tag, n), 64'(bus.r_done),
                     64'(!loop_m && (n == n_last)));
            check_eq($sformatf("%s loops n=%0d", tag, n), 64'(bus.r_loops),
                     loop_m ? 64'(delivered / len) : 64'd0);
        end
        if (loop_m) begin
            bus.r_stop = 1'b1;
            @(negedge r_clk);
            bus.r_stop = 1'b0;
            check_eq({tag, " stop busy"}, 64'(bus.r_busy), 64'd0);
            check_eq({tag, " stop loops"}, 64'(bus.r_loops), 64'(delivered / len));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            check_eq($sformatf("%s idle valid %0d", tag, i), 64'(bus.r_valid), 64'd0);
            check_eq($sformatf("%s idle out %0d", tag, i), bus.r_out, exp_out);
            check_eq($sformatf("%s idle busy %0d", tag, i), 64'(bus.r_busy), 64'd0);
            check_eq($sformatf("%s idle done %0d", tag, i), 64'(bus.r_done), 64'(!loop_m));
        end
    endtask

    initial begin
        bus.r_start  = 1'b0;
        bus.r_stop   = 1'b0;
        bus.r_loop   = 1'b0;
        bus.r_first  = '0;
        bus.r_last   = '0;
        bus.r_div    = '0;
        bus.w_enable = 1'b0;
        bus.w_chan   = '0;
        bus.w_addr   = '0;
        bus.w_in     = '0;
        r_reset_n    = 1'b0;
        repeat (3) @(negedge r_clk);
        exp_out = '0;
        check_eq("reset out", bus.r_out, 64'd0);
        check_eq("reset valid", 64'(bus.r_valid), 64'd0);
        check_eq("reset busy", 64'(bus.r_busy), 64'd0);
        check_eq("reset done", 64'(bus.r_done), 64'd0);
        check_eq("reset loops", 64'(bus.r_loops), 64'd0);
        r_reset_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            mem_write(2'b01, 4'(a), 32'(a));
            mem_write(2'b10, 4'(a), 32'h100 + 32'(a));
        end

        run_play(2, 5, 0, 1'b0, 0, 1'b0, "oneshot");
        run_play(14, 1, 2, 1'b0, 0, 1'b0, "wrap");
        run_play(3, 4, 0, 1'b1, 7, 1'b0, "loop");
        check_eq("loop holds 3", bus.r_out, 64'h0000_0103_0000_0003);

        blind_play(3, 4, 0, 9);
        run_play(8, 8, 0, 1'b0, 0, 1'b0, "restart");

        blind_play(2, 5, 1, 6);
        r_reset_n = 1'b0;
        @(negedge r_clk);
        r_reset_n = 1'b1;
        exp_out = '0;
        check_eq("midreset out", bus.r_out, 64'd0);
        check_eq("midreset valid", 64'(bus.r_valid), 64'd0);
        check_eq("midreset busy", 64'(bus.r_busy), 64'd0);
        check_eq("midreset done", 64'(bus.r_done), 64'd0);
        check_eq("midreset loops", 64'(bus.r_loops), 64'd0);
        run_play(2, 5, 0, 1'b0, 0, 1'b0, "replay");

        mem_write(2'b01, 4'd0, 32'hDEAD);
        run_play(15, 0, 0, 1'b0, 0, 1'b1, "chmask");
        check_eq("chmask ch0 ch1", bus.r_out, 64'h0000_0100_0000_DEAD);

        for (int it = 0; it < 20; it++) begin
            mem_write(2'($urandom), 4'($urandom), $urandom);
            mem_write(2'($urandom), 4'($urandom), $urandom);
            run_play(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(1, 20)),
                     1'($urandom), $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
